// File: rtl/adam_aes_encipher_stream_if.sv
//------------------------------------------------------------------------------
// Module   : adam_aes_encipher_stream_if
// Purpose  : Plaintext-in / ciphertext-out streaming bundle for the AES core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface adam_aes_encipher_stream_if;
  logic [1:0]   keylen;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  modport master (
    output keylen, in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  keylen, in_valid, in_block, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

`default_nettype wire

// File: rtl/adam_aes_encipher_stream.sv
//------------------------------------------------------------------------------
// Module   : adam_aes_encipher_stream
// Purpose  : Iterative AES-128/192/256 encipher core with a result FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adam_aes_sbox_byte (
  input  wire logic [7:0] i_byte,
  output logic      [7:0] o_byte
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign o_byte = sbox(i_byte);
endmodule

module adam_aes_encipher_stream #(
  parameter int SBOX_LANES = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                i_clear,
  adam_aes_encipher_stream_if.slave io_stream,
  output logic [3:0]               o_round,
  input  wire logic [127:0]        i_round_key,
  output logic                     o_busy,
  output logic                     o_cfg_err
);
  localparam int SUBCYC = 16 / SBOX_LANES;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] SUB_LAST = 2'(SUBCYC - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_MIX  = 2'd2;

  generate
    if (SBOX_LANES != 4 && SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
      $error("SBOX_LANES must be 4, 8 or 16");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
      $error("FIFO_DEPTH must be at least 1");
    end
  endgenerate

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State byte n = 4*col + row lives at bits [127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  logic [1:0]       r_fsm;
  logic [127:0]     r_state;
  logic [3:0]       r_rnd;
  logic [3:0]       r_nr;
  logic [1:0]       r_sub_cnt;
  logic             r_cfg_err;
  logic [127:0]     r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [7:0]   w_sbox_in  [SBOX_LANES];
  logic [7:0]   w_sbox_out [SBOX_LANES];
  logic [127:0] w_sub_state;
  logic         w_accept;
  logic         w_push;
  logic         w_pop;
  logic         w_last_rnd;

  generate
    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
      adam_aes_sbox_byte u_sbox (.i_byte(w_sbox_in[l]), .o_byte(w_sbox_out[l]));
    end
  endgenerate

  always_comb begin
    for (int l = 0; l < SBOX_LANES; l++)
      w_sbox_in[l] = r_state[127 - 8*(int'(r_sub_cnt)*SBOX_LANES + l) -: 8];
  end

  always_comb begin
    w_sub_state = r_state;
    for (int l = 0; l < SBOX_LANES; l++)
      w_sub_state[127 - 8*(int'(r_sub_cnt)*SBOX_LANES + l) -: 8] = w_sbox_out[l];
  end

  // Admission requires a free FIFO slot, so the final MIX can always push.
  assign io_stream.in_ready  = (r_fsm == S_IDLE) && (r_count < CNT_W'(FIFO_DEPTH)) &&
                               !i_clear && !reset;
  assign w_accept            = io_stream.in_valid && io_stream.in_ready;
  assign w_last_rnd          = (r_rnd == r_nr);
  assign w_push              = (r_fsm == S_MIX) && w_last_rnd;
  assign w_pop               = (r_count != '0) && io_stream.out_ready;
  assign io_stream.out_valid = (r_count != '0);
  assign io_stream.out_block = (r_count != '0) ? r_fifo[r_rd_ptr] : '0;
  assign o_round             = (r_fsm == S_IDLE) ? 4'd0 : r_rnd;
  assign o_busy              = (r_fsm != S_IDLE);
  assign o_cfg_err           = r_cfg_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm     <= S_IDLE;
      r_state   <= '0;
      r_rnd     <= '0;
      r_nr      <= 4'd10;
      r_sub_cnt <= '0;
      r_cfg_err <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else if (i_clear) begin
      r_fsm     <= S_IDLE;
      r_rnd     <= '0;
      r_sub_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: if (w_accept) begin
          r_state   <= io_stream.in_block ^ i_round_key;
          r_nr      <= (io_stream.keylen == 2'd1) ? 4'd12 :
                       (io_stream.keylen == 2'd2) ? 4'd14 : 4'd10;
          if (io_stream.keylen == 2'd3) r_cfg_err <= 1'b1;
          r_rnd     <= 4'd1;
          r_sub_cnt <= '0;
          r_fsm     <= S_SUB;
        end
        S_SUB: begin
          r_state <= w_sub_state;
          if (r_sub_cnt == SUB_LAST) begin
            r_sub_cnt <= '0;
            r_fsm     <= S_MIX;
          end else begin
            r_sub_cnt <= r_sub_cnt + 2'd1;
          end
        end
        S_MIX: if (w_last_rnd) begin
          r_fsm <= S_IDLE;
        end else begin
          r_state <= mix_columns(shift_rows(r_state)) ^ i_round_key;
          r_rnd   <= r_rnd + 4'd1;
          r_fsm   <= S_SUB;
        end
        default: r_fsm <= S_IDLE;
      endcase

      if (w_push) begin
        r_fifo[r_wr_ptr] <= shift_rows(r_state) ^ i_round_key;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_adam_aes_encipher_stream.sv
//------------------------------------------------------------------------------
// Module   : tb_adam_aes_encipher_stream
// Purpose  : Self-checking bench for the AES encipher stream core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_adam_aes_encipher_stream;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [2047:0] sb_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [127:0] rk [0:14];
  logic [127:0] sb [$];

  logic [3:0]   rnd16, rnd4, rnd8;
  logic [127:0] rk16, rk4, rk8;
  logic         busy16, busy4, busy8, cfg16, cfg4, cfg8;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  adam_aes_encipher_stream_if s16 ();
  adam_aes_encipher_stream_if s4 ();
  adam_aes_encipher_stream_if s8 ();

  assign rk16 = rk[rnd16];
  assign rk4  = rk[rnd4];
  assign rk8  = rk[rnd8];

  adam_aes_encipher_stream #(.SBOX_LANES(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .i_clear(clear), .io_stream(s16),
    .o_round(rnd16), .i_round_key(rk16), .o_busy(busy16), .o_cfg_err(cfg16));
  adam_aes_encipher_stream #(.SBOX_LANES(4), .FIFO_DEPTH(2)) dut4 (
    .clk(clk), .reset(reset), .i_clear(1'b0), .io_stream(s4),
    .o_round(rnd4), .i_round_key(rk4), .o_busy(busy4), .o_cfg_err(cfg4));
  adam_aes_encipher_stream #(.SBOX_LANES(8), .FIFO_DEPTH(2)) dut8 (
    .clk(clk), .reset(reset), .i_clear(1'b0), .io_stream(s8),
    .o_round(rnd8), .i_round_key(rk8), .o_busy(busy8), .o_cfg_err(cfg8));

  function automatic logic [31:0] subw(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[31 - 8*i -: 8] = sb_flat[2047 - 8*int'(w[31 - 8*i -: 8]) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < i; k++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    return r;
  endfunction

  // FIPS-197 key expansion feeding rk[] for the selected key length.
  task automatic expand(input int kl);
    logic [31:0]  w [0:59];
    logic [31:0]  t;
    logic [255:0] k;
    int nk, nr;
    k  = KEY;
    nk = (kl == 1) ? 6 : (kl == 2) ? 8 : 4;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rcon(i / nk);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (s16.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_low got %b exp 0", s16.in_ready);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({rnd16, s16.out_valid, busy16, cfg16, s16.in_ready} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state got rnd=%0d ov=%b busy=%b cfg=%b rdy=%b exp 0 0 0 0 1",
               rnd16, s16.out_valid, busy16, cfg16, s16.in_ready);
    end
    vectors++;
    if (s16.out_block !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_out_block got %h exp 0", s16.out_block);
    end
  endtask

  // One block through the 16-lane core, checking the round sequence and latency.
  task automatic run_one(input logic [1:0] kl, input logic [127:0] exp, input int nr, input string nm);
    logic [127:0] e;
    s16.keylen = kl; s16.in_block = PT; s16.in_valid = 1'b1; s16.out_ready = 1'b0;
    #1;
    vectors++;
    if (s16.in_ready !== 1'b1 || rnd16 !== 4'd0) begin
      miscompares++;
      $display("FAIL %s_accept got rdy=%b rnd=%0d exp 1 0", nm, s16.in_ready, rnd16);
    end
    sb.push_back(exp);
    step();
    s16.in_valid = 1'b0;
    s16.keylen = ~kl;
    for (int r = 1; r <= nr; r++) begin
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (rnd16 !== 4'(r) || busy16 !== 1'b1 || s16.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_round got rnd=%0d busy=%b ov=%b exp rnd=%0d 1 0", nm, rnd16, busy16, s16.out_valid, r);
        end
        step();
      end
    end
    vectors++;
    if (s16.out_valid !== 1'b1 || busy16 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_latency got ov=%b busy=%b exp 1 0 at %0d cycles", nm, s16.out_valid, busy16, 2*nr+1);
    end
    e = sb.pop_front();
    vectors++;
    if (s16.out_block !== e) begin
      miscompares++;
      $display("FAIL %s_ct got %h exp %h", nm, s16.out_block, e);
    end
    s16.out_ready = 1'b1;
    step();
    s16.out_ready = 1'b0;
    #1;
    vectors++;
    if (s16.out_valid !== 1'b0 || s16.out_block !== 128'h0) begin
      miscompares++;
      $display("FAIL %s_pop got ov=%b blk=%h exp 0 0", nm, s16.out_valid, s16.out_block);
    end
  endtask

  task automatic test_lanes();
    int t0, lat4, lat8, n;
    logic [127:0] e;
    expand(0);
    s4.keylen = 2'd0; s4.in_block = PT; s4.in_valid = 1'b1; s4.out_ready = 1'b0;
    s8.keylen = 2'd0; s8.in_block = PT; s8.in_valid = 1'b1; s8.out_ready = 1'b0;
    #1;
    vectors++;
    if (s4.in_ready !== 1'b1 || s8.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lanes_accept got %b %b exp 1 1", s4.in_ready, s8.in_ready);
    end
    sb.push_back(CT128);
    sb.push_back(CT128);
    t0 = cycle;
    step();
    s4.in_valid = 1'b0; s8.in_valid = 1'b0;
    lat4 = -1; lat8 = -1; n = 0;
    while (n < 80 && (lat4 < 0 || lat8 < 0)) begin
      if (lat8 < 0 && s8.out_valid === 1'b1) lat8 = cycle - t0;
      if (lat4 < 0 && s4.out_valid === 1'b1) lat4 = cycle - t0;
      if (lat4 < 0 || lat8 < 0) step();
      n++;
    end
    vectors++;
    if (lat8 != 31) begin
      miscompares++;
      $display("FAIL lanes8_latency got %0d exp 31", lat8);
    end
    vectors++;
    if (lat4 != 51) begin
      miscompares++;
      $display("FAIL lanes4_latency got %0d exp 51", lat4);
    end
    e = sb.pop_front();
    vectors++;
    if (s8.out_block !== e) begin
      miscompares++;
      $display("FAIL lanes8_ct got %h exp %h", s8.out_block, e);
    end
    e = sb.pop_front();
    vectors++;
    if (s4.out_block !== e) begin
      miscompares++;
      $display("FAIL lanes4_ct got %h exp %h", s4.out_block, e);
    end
    s4.out_ready = 1'b1; s8.out_ready = 1'b1;
    step();
    s4.out_ready = 1'b0; s8.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t0, d;
    logic rdy_seen, hold_bad;
    logic [127:0] e;
    expand(0);
    s16.keylen = 2'd0; s16.in_block = PT; s16.in_valid = 1'b1; s16.out_ready = 1'b0;
    #1;
    t0 = cycle;
    sb.push_back(CT128);
    step();
    s16.keylen = 2'd1;
    d = 0;
    while (d < 40 && s16.in_ready !== 1'b1) begin
      step();
      d++;
    end
    vectors++;
    if (cycle - t0 != 21) begin
      miscompares++;
      $display("FAIL b2b_second_accept got %0d exp 21", cycle - t0);
    end
    vectors++;
    if (s16.out_valid !== 1'b1 || s16.out_block !== sb[0]) begin
      miscompares++;
      $display("FAIL b2b_first_queued got ov=%b blk=%h exp 1 %h", s16.out_valid, s16.out_block, sb[0]);
    end
    expand(1);
    sb.push_back(CT192);
    step();
    rdy_seen = 1'b0; hold_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s16.in_ready === 1'b1) rdy_seen = 1'b1;
      if (s16.out_block !== sb[0]) hold_bad = 1'b1;
      step();
    end
    vectors++;
    if (rdy_seen !== 1'b0 || busy16 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full_blocks got rdy_seen=%b busy=%b exp 0 0", rdy_seen, busy16);
    end
    vectors++;
    if (hold_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold got changed=%b exp 0", hold_bad);
    end
    s16.in_valid = 1'b0;
    s16.out_ready = 1'b1;
    #1;
    e = sb.pop_front();
    vectors++;
    if (s16.out_block !== e) begin
      miscompares++;
      $display("FAIL b2b_pop1 got %h exp %h", s16.out_block, e);
    end
    step();
    s16.out_ready = 1'b0;
    #1;
    vectors++;
    if (s16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_after_pop got %b exp 1", s16.in_ready);
    end
    e = sb.pop_front();
    vectors++;
    if (s16.out_valid !== 1'b1 || s16.out_block !== e) begin
      miscompares++;
      $display("FAIL b2b_pop2 got ov=%b blk=%h exp 1 %h", s16.out_valid, s16.out_block, e);
    end
    s16.out_ready = 1'b1;
    step();
    s16.out_ready = 1'b0;
  endtask

  task automatic test_clear();
    int n;
    expand(0);
    s16.keylen = 2'd0; s16.in_block = PT; s16.in_valid = 1'b1; s16.out_ready = 1'b0;
    step();
    s16.in_valid = 1'b0;
    n = 0;
    while (n < 40 && s16.out_valid !== 1'b1) begin
      step();
      n++;
    end
    vectors++;
    if (s16.out_block !== CT128) begin
      miscompares++;
      $display("FAIL clear_queued_ct got %h exp %h", s16.out_block, CT128);
    end
    s16.in_valid = 1'b1;
    step();
    s16.in_valid = 1'b0;
    n = 0;
    while (n < 20 && rnd16 !== 4'd5) begin
      step();
      n++;
    end
    clear = 1'b1;
    s16.in_valid = 1'b1;
    #1;
    vectors++;
    if (rnd16 !== 4'd5 || s16.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_mid_sub got rnd=%0d rdy=%b exp 5 0", rnd16, s16.in_ready);
    end
    step();
    clear = 1'b0;
    s16.in_valid = 1'b0;
    #1;
    vectors++;
    if ({rnd16, s16.out_valid, busy16, s16.in_ready} !== {4'd0, 1'b0, 1'b0, 1'b1} || s16.out_block !== 128'h0) begin
      miscompares++;
      $display("FAIL clear_state got rnd=%0d ov=%b busy=%b rdy=%b blk=%h exp 0 0 0 1 0",
               rnd16, s16.out_valid, busy16, s16.in_ready, s16.out_block);
    end
    sb.delete();
    run_one(2'd0, CT128, 10, "post_clear");
  endtask

  task automatic test_cfg_err();
    int n;
    expand(0);
    run_one(2'd3, CT128, 10, "keylen3");
    vectors++;
    if (cfg16 !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_set got %b exp 1", cfg16);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    vectors++;
    if (cfg16 !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_sticky got %b exp 1", cfg16);
    end
    s16.keylen = 2'd0; s16.in_block = PT; s16.in_valid = 1'b1; s16.out_ready = 1'b0;
    step();
    s16.in_valid = 1'b0;
    n = 0;
    while (n < 40 && s16.out_valid !== 1'b1) begin
      step();
      n++;
    end
    s16.in_valid = 1'b1;
    step();
    s16.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    #1;
    vectors++;
    if (s16.in_ready !== 1'b0 || busy16 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_block_pre got rdy=%b busy=%b exp 0 1", s16.in_ready, busy16);
    end
    step();
    reset = 1'b0;
    #1;
    vectors++;
    if ({rnd16, s16.out_valid, busy16, cfg16, s16.in_ready} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1} || s16.out_block !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_mid_block got rnd=%0d ov=%b busy=%b cfg=%b rdy=%b blk=%h exp 0 0 0 0 1 0",
               rnd16, s16.out_valid, busy16, cfg16, s16.in_ready, s16.out_block);
    end
  endtask

  initial begin
    s16.keylen = 2'd0; s16.in_valid = 1'b0; s16.in_block = '0; s16.out_ready = 1'b0;
    s4.keylen  = 2'd0; s4.in_valid  = 1'b0; s4.in_block  = '0; s4.out_ready  = 1'b0;
    s8.keylen  = 2'd0; s8.in_valid  = 1'b0; s8.in_block  = '0; s8.out_ready  = 1'b0;
    for (int i = 0; i < 15; i++) rk[i] = '0;
    test_reset();
    expand(0);
    run_one(2'd0, CT128, 10, "aes128");
    expand(1);
    run_one(2'd1, CT192, 12, "aes192");
    expand(2);
    run_one(2'd2, CT256, 14, "aes256");
    test_lanes();
    test_back_to_back();
    test_clear();
    test_cfg_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/adam_aes_encipher_stream.md
Name: adam_aes_encipher_stream

Overview:
Parametrised iterative AES encipher core with valid/ready streaming interfaces, runtime-selectable AES-128/192/256, configurable S-box lane count (area/latency trade), and an output result FIFO. The next core can start while the previous result waits for the consumer. Round keys come from the external key-expansion block, indexed by the `round` output. The block sits between the AES register/DMA front-end and the key-memory block in the periph AES core.

Parameters:
SBOX_LANES, 16, bytes substituted per cycle; legal values are 4, 8 and 16, and any other value is an elaboration error. SUBCYC = 16/SBOX_LANES.
FIFO_DEPTH, 2, output result FIFO entries; must be 1 or more.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous abort: drops the in-flight block and empties the FIFO
keylen  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved; sampled at accept
in_valid  in  1  input block valid
in_ready  out  1  core can accept a block
in_block  in  128  plaintext; [127:120] is state byte 0 (FIPS-197 column-major)
round  out  4  index of the round key required this cycle
round_key  in  128  round key for `round`; combinationally valid in the same cycle
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts the FIFO head
out_block  out  128  ciphertext at the FIFO head
busy  out  1  a block is in flight
cfg_err  out  1  sticky; set when keylen=3 is accepted

Behaviour:
- Reset: one clock, synchronous, active-high (reset); all state is cleared synchronously.
  - State machine goes to IDLE; FIFO is empty.
  - round=0, out_valid=0, out_block=0, busy=0, cfg_err=0.
  - in_ready is forced 0 while reset is high and is 1 in the first cycle after reset falls.
- Nr is 10, 12 or 14 for keylen 0, 1, 2. keylen=3 runs as AES-128 and sets cfg_err; only reset clears cfg_err.
- in_ready = (state==IDLE) & (fifo_count < FIFO_DEPTH) & ~clear. This reserves a FIFO slot before accepting, so a push never meets a full FIFO.
- States: IDLE -> SUB -> MIX -> (SUB | IDLE).
  - IDLE: round=0. On accept: state_reg <= in_block ^ round_key, keylen is latched, rnd <= 1, go to SUB.
  - SUB: lasts SUBCYC cycles. Each cycle substitutes SBOX_LANES bytes of state_reg in place using SBOX_LANES internal adam_aes_sbox_byte instances. round=rnd. round_key is ignored.
  - MIX: one cycle, round=rnd.
    - If rnd<Nr: state_reg <= MixColumns(ShiftRows(state_reg)) ^ round_key; rnd++; go to SUB.
    - If rnd==Nr: push ShiftRows(state_reg) ^ round_key into the FIFO; go to IDLE.
- Latency: accept edge to out_valid = Nr*(SUBCYC+1)+1 cycles.
  - SBOX_LANES=16: 21, 25, 29 cycles for AES-128, 192, 256.
  - SBOX_LANES=4: 51 cycles for AES-128.
- Throughput: in_ready rises in the cycle after the final MIX, so back-to-back accept is possible. Block period is Nr*(SUBCYC+1)+1 cycles.
- FIFO behaviour:
  - There is no bypass; a pushed entry is visible the cycle after the push.
  - Pop on out_valid & out_ready. Push and pop in the same cycle are both honoured and the count is unchanged.
  - out_block holds its value while out_valid=1 and out_ready=0.
  - out_block is 0 when the FIFO is empty.
- busy=1 in SUB and MIX.
- The keylen latch is ignored except at accept; changing keylen mid-block has no effect.
- clear (priority below reset, above everything else):
  - Next cycle: IDLE, FIFO empty, out_valid=0, round=0.
  - An in_valid present during clear is not accepted.
  - A MIX push coinciding with clear is discarded.
  - cfg_err is unaffected.
- Reset mid-operation is identical to clear, plus cfg_err is cleared.
- round_key is sampled only in the IDLE accept cycle and in MIX cycles.

Test Plan:
1. Bench round keys come from the expansion model; FIPS-197 C.1, keylen=0, SBOX_LANES=16. Plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 21 cycles after accept; round sequence 0,1,1,2,2,...,10,10.
2. Same plaintext with keylen=1, key 000102..17 -> dda97ca4864cdfe06eaf70a0ec0d7191 at 25 cycles. With keylen=2, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 at 29 cycles.
3. SBOX_LANES=4 build, vector 1 -> same ciphertext at 51 cycles. SBOX_LANES=8 -> 31 cycles.
4. FIFO_DEPTH=2, out_ready=0, three blocks offered:
   - Two are accepted back-to-back (second accept in the cycle after the first's final MIX).
   - in_ready stays 0 with 2 entries queued.
   - Raising out_ready for 1 cycle pops the first result in order and re-enables in_ready the next cycle.
5. Assert clear mid-SUB of round 5 with 1 entry queued -> next cycle IDLE, out_valid=0, round=0. A new block is then accepted and produces the correct ciphertext.
6. keylen=3 with vector 1 -> ciphertext 69c4e0d8..., cfg_err=1 and sticky across clear. Assert reset for 1 cycle mid-round -> all outputs 0, cfg_err=0; in_ready=1 the next cycle.
